// File: rtl/uart_rx_fifo_if.sv
// Bundle of the receiver's serial input, FIFO read side, error flags and
// FSM debug state. The slave modport is the receiver, the master is its user.
//
// Read handshake: the FIFO head is always visible on data_out while empty=0.
// rd_en high on a clock edge with empty=0 pops the head. rd_en with empty=1
// is ignored. There is no back-pressure on the serial side. A byte arriving
// while full is dropped and flagged unless the same edge also pops.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          uart_rxd;
  logic          rd_en;
  logic          clr_err;
  logic [7:0]    data_out;
  logic          empty;
  logic          full;
  logic [LW-1:0] fill_level;
  logic          frame_error;
  logic          parity_error;
  logic          overrun;
  logic [2:0]    state;

  modport master (
    output uart_rxd, rd_en, clr_err,
    input  data_out, empty, full, fill_level,
    input  frame_error, parity_error, overrun, state
  );

  modport slave (
    input  uart_rxd, rd_en, clr_err,
    output data_out, empty, full, fill_level,
    output frame_error, parity_error, overrun, state
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-vote bit sampling,
// configurable parity and stop bits, feeding a first-word fall-through FIFO
// with sticky frame, parity and overrun flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ    = 3686400,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DIV = CLK_FREQ / (16 * BAUD_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    sync;
  logic          rxd_s;

  state_t        state;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [1:0]    samp;
  logic [7:0]    shreg;
  logic          maj;
  logic          par_exp;
  logic          wr_req;
  logic [7:0]    wr_data;
  logic          frame_evt;
  logic          parity_evt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic [7:0]    data_out;
  logic [7:0]    head_next;
  logic          is_full;
  logic          do_rd;
  logic          do_wr;
  logic          ovr_evt;
  logic          frame_error;
  logic          parity_error;
  logic          overrun;

  // Oversampling enable: one-cycle pulse every DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Two-flop synchroniser; loads idle (1) during reset.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], bus.uart_rxd};
  end
  assign rxd_s = sync[1];

  // Majority of ticks 7, 8 and the live value at tick 9.
  assign maj = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);

  // Expected parity bit; bits above DATA_BITS are zero in shreg.
  always_comb begin
    par_exp = 1'b0;
    case (PARITY_MODE)
      1:       par_exp = ^shreg;
      2:       par_exp = ~^shreg;
      3:       par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  // Receive FSM: advances only on ticks, emits one-cycle write/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      samp       <= '0;
      shreg      <= '0;
      wr_req     <= 1'b0;
      wr_data    <= '0;
      frame_evt  <= 1'b0;
      parity_evt <= 1'b0;
    end else begin
      wr_req     <= 1'b0;
      frame_evt  <= 1'b0;
      parity_evt <= 1'b0;
      if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (tick_cnt == 4'd7) samp[0] <= rxd_s;
        if (tick_cnt == 4'd8) samp[1] <= rxd_s;
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            if (!rxd_s) begin
              state    <= START;
              shreg    <= '0;
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt == 4'd9 && maj) state <= IDLE;
            else if (tick_cnt == 4'd15)  state <= DATA;
          end
          DATA: begin
            if (tick_cnt == 4'd9) shreg[bit_cnt] <= maj;
            if (tick_cnt == 4'd15) begin
              if (bit_cnt == 3'(DATA_BITS - 1))
                state <= (PARITY_MODE != 0) ? PARITY : STOP;
              else
                bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == 4'd9 && maj != par_exp) parity_evt <= 1'b1;
            if (tick_cnt == 4'd15) state <= STOP;
          end
          STOP: begin
            if (tick_cnt == 4'd9) begin
              if (!maj) begin
                frame_evt <= 1'b1;
                state     <= IDLE;
              end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
                wr_req  <= 1'b1;
                wr_data <= shreg;
                state   <= IDLE;
              end
            end else if (tick_cnt == 4'd15) begin
              stop_cnt <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign is_full = (count == (AW + 1)'(FIFO_DEPTH));
  assign do_rd   = bus.rd_en && (count != '0);
  assign do_wr   = wr_req && (!is_full || do_rd);
  assign ovr_evt = wr_req && is_full && !bus.rd_en;
  assign rd_next = do_rd ? rd_ptr + 1'b1 : rd_ptr;

  // Head after this edge: bypass the incoming byte when it lands in an empty FIFO.
  always_comb begin
    head_next = mem[rd_next];
    if (do_wr && ((count == '0) || (count == (AW + 1)'(1) && do_rd)))
      head_next = wr_data;
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, level and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_next;
      data_out <= head_next;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a same-cycle event overrides a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_error  <= frame_evt  | (frame_error  & ~bus.clr_err);
      parity_error <= parity_evt | (parity_error & ~bus.clr_err);
      overrun      <= ovr_evt    | (overrun      & ~bus.clr_err);
    end
  end

  assign bus.data_out     = data_out;
  assign bus.empty        = (count == '0);
  assign bus.full         = is_full;
  assign bus.fill_level   = count;
  assign bus.frame_error  = frame_error;
  assign bus.parity_error = parity_error;
  assign bus.overrun      = overrun;
  assign bus.state        = state;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance with a 4-entry FIFO and a 7E2
// instance with a 16-entry FIFO, both at 32 clocks per bit.
module tb_uart_rx_fifo;
  localparam int BIT_CLKS = 32;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_STOP = 3'd4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  uart_rx_fifo_if #(.FIFO_DEPTH(4))  bus_a ();
  uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus_b ();

  uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8n1 (.clk(clk), .rst(rst), .bus(bus_a));
  uart_rx_fifo #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(16))
    u_7e2 (.clk(clk), .rst(rst), .bus(bus_b));

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_rxd(input bit sel, input logic v);
    if (sel) bus_b.uart_rxd = v;
    else     bus_a.uart_rxd = v;
  endtask

  task automatic send_bit(input bit sel, input logic v);
    drive_rxd(sel, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input int nbits,
                            input bit has_par, input logic par, input int nstop,
                            input logic stop_v);
    @(negedge clk);
    send_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(sel, data[i]);
    if (has_par) send_bit(sel, par);
    for (int s = 0; s < nstop; s++) send_bit(sel, stop_v);
    drive_rxd(sel, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_clr(input bit sel);
    @(negedge clk);
    if (sel) bus_b.clr_err = 1'b1; else bus_a.clr_err = 1'b1;
    @(negedge clk);
    bus_a.clr_err = 1'b0;
    bus_b.clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard pop: compare the head against the expected queue, then read.
  task automatic pop(input bit sel, input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    logic       emp;
    int         qsz;
    @(negedge clk);
    emp = sel ? bus_b.empty : bus_a.empty;
    got = sel ? bus_b.data_out : bus_a.data_out;
    qsz = sel ? exp_b.size() : exp_a.size();
    check({tag, " sb_nonempty"}, 32'(qsz > 0), 32'd1);
    check({tag, " empty"}, 32'(emp), 32'd0);
    if (qsz > 0) begin
      exp = sel ? exp_b.pop_front() : exp_a.pop_front();
      check({tag, " data"}, 32'(got), 32'(exp));
    end
    if (sel) bus_b.rd_en = 1'b1; else bus_a.rd_en = 1'b1;
    @(negedge clk);
    bus_a.rd_en = 1'b0;
    bus_b.rd_en = 1'b0;
  endtask

  function automatic logic [2:0] flags_a();
    return {bus_a.frame_error, bus_a.parity_error, bus_a.overrun};
  endfunction

  initial begin
    logic [7:0] b;
    logic [7:0] got;
    logic [7:0] exp;
    bit seen_stop;
    bit hit;

    bus_a.uart_rxd = 1'b1; bus_a.rd_en = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.uart_rxd = 1'b1; bus_b.rd_en = 1'b0; bus_b.clr_err = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst empty_a", 32'(bus_a.empty), 32'd1);
    check("rst full_a", 32'(bus_a.full), 32'd0);
    check("rst fill_a", 32'(bus_a.fill_level), 32'd0);
    check("rst data_a", 32'(bus_a.data_out), 32'd0);
    check("rst flags_a", 32'(flags_a()), 32'd0);
    check("rst state_a", 32'(bus_a.state), 32'(ST_IDLE));
    check("rst empty_b", 32'(bus_b.empty), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 single byte
    exp_a.push_back(8'hA5);
    send_frame(0, 8'hA5, 8, 0, 1'b0, 1, 1'b1);
    check("8n1 fill", 32'(bus_a.fill_level), 32'd1);
    check("8n1 data", 32'(bus_a.data_out), 32'hA5);
    check("8n1 flags", 32'(flags_a()), 32'd0);
    pop(0, "8n1 pop");
    check("8n1 empty_after", 32'(bus_a.empty), 32'd1);

    // 7E2: good parity, then bad parity (byte still stored)
    exp_b.push_back(8'h41);
    send_frame(1, 8'h41, 7, 1, 1'b0, 2, 1'b1);
    check("7e2 fill1", 32'(bus_b.fill_level), 32'd1);
    check("7e2 perr0", 32'(bus_b.parity_error), 32'd0);
    check("7e2 data", 32'(bus_b.data_out), 32'h41);
    exp_b.push_back(8'h41);
    send_frame(1, 8'h41, 7, 1, 1'b1, 2, 1'b1);
    check("7e2 fill2", 32'(bus_b.fill_level), 32'd2);
    check("7e2 perr1", 32'(bus_b.parity_error), 32'd1);
    check("7e2 ferr", 32'(bus_b.frame_error), 32'd0);
    pop(1, "7e2 pop1");
    pop(1, "7e2 pop2");
    check("7e2 empty", 32'(bus_b.empty), 32'd1);
    pulse_clr(1);
    check("7e2 perr_clr", 32'(bus_b.parity_error), 32'd0);

    // Frame error: stop bit low, nothing stored
    send_frame(0, 8'h3C, 8, 0, 1'b0, 1, 1'b0);
    repeat (60) @(negedge clk);
    check("ferr flag", 32'(bus_a.frame_error), 32'd1);
    check("ferr fill", 32'(bus_a.fill_level), 32'd0);
    check("ferr state", 32'(bus_a.state), 32'(ST_IDLE));
    pulse_clr(0);
    check("ferr clr", 32'(bus_a.frame_error), 32'd0);

    // Glitch: 4 clocks low only
    @(negedge clk);
    bus_a.uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus_a.uart_rxd = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch state", 32'(bus_a.state), 32'(ST_IDLE));
    check("glitch fill", 32'(bus_a.fill_level), 32'd0);
    check("glitch flags", 32'(flags_a()), 32'd0);

    // Reset in the middle of a frame aborts it
    @(negedge clk);
    bus_a.uart_rxd = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rst = 1'b1;
    bus_a.uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("midrst fill", 32'(bus_a.fill_level), 32'd0);
    check("midrst state", 32'(bus_a.state), 32'(ST_IDLE));
    exp_a.push_back(8'h5A);
    send_frame(0, 8'h5A, 8, 0, 1'b0, 1, 1'b1);
    pop(0, "midrst pop");

    // Overrun with no reads
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_a.push_back(8'(i));
      send_frame(0, 8'(i), 8, 0, 1'b0, 1, 1'b1);
    end
    check("ovr full", 32'(bus_a.full), 32'd1);
    check("ovr fill", 32'(bus_a.fill_level), 32'd4);
    check("ovr flag", 32'(bus_a.overrun), 32'd1);
    for (int i = 0; i < 4; i++) pop(0, "ovr pop");
    @(negedge clk);
    check("ovr empty", 32'(bus_a.empty), 32'd1);
    pulse_clr(0);
    check("ovr clr", 32'(bus_a.overrun), 32'd0);

    // Fill, then write and read in the same cycle at FULL
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(8'h10 + 8'(i));
      send_frame(0, 8'h10 + 8'(i), 8, 0, 1'b0, 1, 1'b1);
    end
    check("conc full", 32'(bus_a.full), 32'd1);
    exp_a.push_back(8'h14);
    seen_stop = 1'b0;
    hit = 1'b0;
    fork
      send_frame(0, 8'h14, 8, 0, 1'b0, 1, 1'b1);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (bus_a.state == ST_STOP) seen_stop = 1'b1;
          else if (seen_stop && bus_a.state == ST_IDLE) begin
            hit = 1'b1;
            break;
          end
        end
        if (hit) begin
          got = bus_a.data_out;
          exp = exp_a.pop_front();
          check("conc head", 32'(got), 32'(exp));
          bus_a.rd_en = 1'b1;
          @(negedge clk);
          bus_a.rd_en = 1'b0;
        end
      end
    join
    check("conc write_seen", 32'(hit), 32'd1);
    check("conc fill", 32'(bus_a.fill_level), 32'd4);
    check("conc ovr", 32'(bus_a.overrun), 32'd0);

    // 20 further bytes through the wrapping FIFO, kept near full
    for (int k = 0; k < 20; k++) begin
      pop(0, "wrap pop");
      b = 8'($urandom_range(0, 255));
      exp_a.push_back(b);
      send_frame(0, b, 8, 0, 1'b0, 1, 1'b1);
      check("wrap fill", 32'(bus_a.fill_level), 32'd4);
    end
    for (int i = 0; i < 4; i++) pop(0, "drain pop");
    @(negedge clk);
    check("final empty", 32'(bus_a.empty), 32'd1);
    check("final flags", 32'(flags_a()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
